// File: rtl/corr_pkg.sv
// Shared constants, state type and width check for the correlation responder.
package corr_pkg;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int COORD_W  = 13;
  localparam int FRAME_AW = 19;
  localparam int TPL_AW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } corrState_t;

  // Sum of tplPix products of two pixW-bit values must fit in accW bits.
  function automatic bit accWidthOk(input int accW, input int pixW, input int tplPix);
    return accW >= 2 * pixW + $clog2(tplPix);
  endfunction

endpackage

// File: rtl/corr_addr_gen.sv
// Window scan counters for the correlation responder: frame/template read
// addresses, in-frame flag and last-issue flag for the current (i, j).
module corr_addr_gen
  import corr_pkg::*;
#(
  parameter int TPL_W = 16,
  parameter int TPL_H = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                issue,
  input  logic [COORD_W-1:0]  xStart,
  input  logic [COORD_W-1:0]  yStart,
  output logic [FRAME_AW-1:0] frameAddr,
  output logic [TPL_AW-1:0]   tplAddr,
  output logic                inFrame,
  output logic                lastIssue
);

  localparam int IW = (TPL_W > 1) ? $clog2(TPL_W) : 1;
  localparam int JW = (TPL_H > 1) ? $clog2(TPL_H) : 1;
  localparam int PW = COORD_W + 1;

  logic [COORD_W-1:0] xBase, yBase;
  logic [IW-1:0]      i;
  logic [JW-1:0]      j;
  logic [PW-1:0]      xPos, yPos;

  always_ff @(posedge clk) begin
    if (rst) begin
      xBase <= '0;
      yBase <= '0;
      i     <= '0;
      j     <= '0;
    end else if (accept) begin
      xBase <= xStart;
      yBase <= yStart;
      i     <= '0;
      j     <= '0;
    end else if (issue) begin
      if (i == IW'(TPL_W - 1)) begin
        i <= '0;
        j <= (j == JW'(TPL_H - 1)) ? '0 : j + 1'b1;
      end else begin
        i <= i + 1'b1;
      end
    end
  end

  // One extra coordinate bit so X+i / Y+j never wrap back into the frame.
  always_comb begin
    xPos      = {1'b0, xBase} + PW'(i);
    yPos      = {1'b0, yBase} + PW'(j);
    inFrame   = (xPos < PW'(H_RES)) && (yPos < PW'(V_RES));
    frameAddr = FRAME_AW'(yPos) * FRAME_AW'(H_RES) + FRAME_AW'(xPos);
    tplAddr   = TPL_AW'(j) * TPL_AW'(TPL_W) + TPL_AW'(i);
    lastIssue = (i == IW'(TPL_W - 1)) && (j == JW'(TPL_H - 1));
  end

endmodule

// File: rtl/corr_engine.sv
// Correlation responder: sums frame x template pixel products over one window.
// CORR_SAT_EN selects a saturating oCorr; otherwise oCorr is the top 16 acc bits.
//
// state | meaning
// IDLE  | waiting for iStart
// ISSUE | one frame/template read pair per cycle, TPL_W*TPL_H cycles
// DRAIN | read latency + product + accumulate pipeline emptying
// DONE  | oCorrFinished pulse, oCorr updated
module corr_engine
  import corr_pkg::*;
#(
  parameter int TPL_W    = 16,
  parameter int TPL_H    = 16,
  parameter int PIX_W    = 8,
  parameter int READ_LAT = 1,
  parameter int ACC_W    = 24
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iStart,
  input  logic [COORD_W-1:0]  iX,
  input  logic [COORD_W-1:0]  iY,
  output logic                oBusy,
  output logic                oCorrFinished,
  output logic [15:0]         oCorr,
  output logic [FRAME_AW-1:0] oFrameAddr,
  output logic                oFrameRd,
  input  logic [PIX_W-1:0]    iFrameData,
  output logic [TPL_AW-1:0]   oTplAddr,
  input  logic [PIX_W-1:0]    iTplData
);

  localparam int PROD_W = 2 * PIX_W;
  localparam int DW     = $clog2(READ_LAT + 2);

  if (!accWidthOk(ACC_W, PIX_W, TPL_W * TPL_H)) begin : gAccCheck
    $error("corr_engine: ACC_W too small for template size and pixel width");
  end

  corrState_t          state;
  logic [DW-1:0]       drainCnt;
  logic                accept, issue, inFrame, lastIssue;
  logic [READ_LAT-1:0] vldDly, inDly;
  logic [PROD_W-1:0]   prod;
  logic                prodVld;
  logic [ACC_W-1:0]    acc;
  logic [15:0]         corrMap;

  assign accept   = (state == IDLE) && iStart;
  assign issue    = (state == ISSUE);
  assign oFrameRd = issue && inFrame;

  corr_addr_gen #(.TPL_W(TPL_W), .TPL_H(TPL_H)) uAddrGen (
    .clk      (iCLK),
    .rst      (iRST),
    .accept   (accept),
    .issue    (issue),
    .xStart   (iX),
    .yStart   (iY),
    .frameAddr(oFrameAddr),
    .tplAddr  (oTplAddr),
    .inFrame  (inFrame),
    .lastIssue(lastIssue)
  );

  // Issue/in-frame flags travel with the read data; out-of-frame products become 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vldDly  <= '0;
      inDly   <= '0;
      prod    <= '0;
      prodVld <= 1'b0;
      acc     <= '0;
    end else begin
      vldDly  <= (vldDly << 1) | READ_LAT'(issue);
      inDly   <= (inDly << 1) | READ_LAT'(issue && inFrame);
      prodVld <= vldDly[READ_LAT-1];
      prod    <= inDly[READ_LAT-1] ? PROD_W'(iFrameData) * PROD_W'(iTplData) : '0;
      if (accept)
        acc <= '0;
      else if (prodVld)
        acc <= acc + ACC_W'(prod);
    end
  end

`ifdef CORR_SAT_EN
  always_comb begin
    corrMap = (acc > ACC_W'(17'h0FFFF)) ? 16'hFFFF : acc[15:0];
  end
`else
  logic unusedAccLow;
  assign unusedAccLow = ^acc[ACC_W-17:0];
  always_comb begin
    corrMap = acc[ACC_W-1 -: 16];
  end
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state         <= IDLE;
      drainCnt      <= '0;
      oBusy         <= 1'b0;
      oCorrFinished <= 1'b0;
      oCorr         <= '0;
    end else begin
      oCorrFinished <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            state <= ISSUE;
            oBusy <= 1'b1;
          end
        end
        ISSUE: begin
          if (lastIssue) begin
            state    <= DRAIN;
            drainCnt <= DW'(READ_LAT + 1);
          end
        end
        DRAIN: begin
          if (drainCnt == '0) begin
            state         <= DONE;
            oCorrFinished <= 1'b1;
            oCorr         <= corrMap;
          end else begin
            drainCnt <= drainCnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_engine.sv
// Self-checking bench for corr_engine: directed vector table, randomized
// windows against a window-sum reference model, busy-restart and reset-abort.
module tb_corr_engine;

  localparam int RL    = 1;
  localparam int ACC_W = 24;
  localparam int N     = 256;
  localparam int LAT   = N + RL + 3;

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic [12:0] iX = '0, iY = '0;
  logic        oBusy, oCorrFinished, oFrameRd;
  logic [15:0] oCorr;
  logic [18:0] oFrameAddr;
  logic [7:0]  oTplAddr;
  logic [7:0]  iFrameData, iTplData;

  corr_engine #(.READ_LAT(RL), .ACC_W(ACC_W)) dut (
    .iCLK(clk), .iRST(iRST), .iStart(iStart), .iX(iX), .iY(iY),
    .oBusy(oBusy), .oCorrFinished(oCorrFinished), .oCorr(oCorr),
    .oFrameAddr(oFrameAddr), .oFrameRd(oFrameRd), .iFrameData(iFrameData),
    .oTplAddr(oTplAddr), .iTplData(iTplData)
  );

  always #10 clk = ~clk;

  // Memory contents: frame is either a constant or an address hash.
  logic [7:0]  tpl[256];
  int          frameMode = 0;
  logic [7:0]  frameVal = 8'd0;
  int unsigned seed = 0;

  function automatic logic [7:0] pix(input int unsigned a);
    if (frameMode == 0) return frameVal;
    return 8'((a * 32'd2654435761 + seed) >> 13);
  endfunction

  logic [7:0] fPipe[RL];
  logic [7:0] tPipe[RL];
  always @(posedge clk) begin
    fPipe[0] <= oFrameRd ? pix(32'(oFrameAddr)) : 8'($urandom);
    tPipe[0] <= tpl[oTplAddr];
    for (int k = 1; k < RL; k++) begin
      fPipe[k] <= fPipe[k-1];
      tPipe[k] <= tPipe[k-1];
    end
  end
  assign iFrameData = fPipe[RL-1];
  assign iTplData   = tPipe[RL-1];

  int rdCount = 0, badAddrCount = 0, doneCount = 0;
  always @(posedge clk) begin
    if (oFrameRd) rdCount++;
    if (oFrameRd && oFrameAddr >= 19'd307200) badAddrCount++;
    if (oCorrFinished) doneCount++;
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference: direct window sum over in-frame pixels.
  task automatic model(input int x, input int y, output longint acc, output int nrd);
    acc = 0;
    nrd = 0;
    for (int j = 0; j < 16; j++)
      for (int i = 0; i < 16; i++)
        if (x + i < 640 && y + j < 480) begin
          acc += longint'(pix((y + j) * 640 + x + i)) * longint'(tpl[j * 16 + i]);
          nrd++;
        end
  endtask

  function automatic longint mapCorr(input longint acc);
`ifdef CORR_SAT_EN
    return (acc > 65535) ? 65535 : acc;
`else
    return acc >> (ACC_W - 16);
`endif
  endfunction

  task automatic runJob(input int x, input int y, input longint expAcc, input int expRd,
                        input bit poke, input string name);
    int lat, rd0, d0, ba0;
    @(negedge clk);
    check({name, "_idle"}, oBusy, 0);
    iX = 13'(x); iY = 13'(y); iStart = 1'b1;
    rd0 = rdCount; d0 = doneCount; ba0 = badAddrCount;
    @(negedge clk);
    iStart = 1'b0;
    lat = 1;
    check({name, "_busy"}, oBusy, 1);
    while (!oCorrFinished && lat < 400) begin
      if (poke && lat >= 10 && lat < 20) begin
        iStart = 1'b1; iX = 13'd5; iY = 13'd7;
      end else begin
        iStart = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    iStart = 1'b0;
    check({name, "_lat"}, lat, LAT);
    check({name, "_corr"}, oCorr, mapCorr(expAcc));
    check({name, "_reads"}, rdCount - rd0, expRd);
    check({name, "_addr"}, badAddrCount - ba0, 0);
    @(negedge clk);
    check({name, "_pulse"}, oCorrFinished, 0);
    check({name, "_endbusy"}, oBusy, 0);
    check({name, "_dones"}, doneCount - d0, 1);
    check({name, "_hold"}, oCorr, mapCorr(expAcc));
  endtask

  typedef struct {
    int     x, y;
    int     fVal, tVal;
    longint expAcc;
    int     expRd;
    string  name;
  } vec_t;

  vec_t   vecs[5];
  longint eAcc;
  int     eRd;

  initial begin
    vecs[0] = '{0,   0,   1,   2,   64'h200,    256, "ones_twos"};
    vecs[1] = '{100, 100, 255, 255, 64'hFE0100, 256, "max_pix"};
    vecs[2] = '{632, 0,   1,   1,   128,        128, "right_edge"};
    vecs[3] = '{639, 479, 7,   9,   63,         1,   "corner"};
    vecs[4] = '{630, 475, 2,   3,   300,        50,  "bottom_right"};

    for (int k = 0; k < 256; k++) tpl[k] = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", oBusy, 0);
    check("rst_done", oCorrFinished, 0);
    check("rst_corr", oCorr, 0);
    check("rst_rd", oFrameRd, 0);
    check("rst_faddr", oFrameAddr, 0);
    check("rst_taddr", oTplAddr, 0);
    iRST = 1'b0;

    for (int v = 0; v < 5; v++) begin
      frameMode = 0;
      frameVal  = 8'(vecs[v].fVal);
      for (int k = 0; k < 256; k++) tpl[k] = 8'(vecs[v].tVal);
      runJob(vecs[v].x, vecs[v].y, vecs[v].expAcc, vecs[v].expRd, 1'b0, vecs[v].name);
    end

    frameMode = 1;
    for (int r = 0; r < 8; r++) begin
      int x, y;
      seed = $urandom;
      for (int k = 0; k < 256; k++) tpl[k] = 8'($urandom);
      x = (r % 2 == 0) ? int'($urandom_range(600, 660)) : int'($urandom_range(0, 700));
      y = (r % 2 == 0) ? int'($urandom_range(0, 520)) : int'($urandom_range(450, 500));
      model(x, y, eAcc, eRd);
      runJob(x, y, eAcc, eRd, 1'b0, $sformatf("rand%0d", r));
    end

    seed = $urandom;
    for (int k = 0; k < 256; k++) tpl[k] = 8'($urandom);
    model(40, 30, eAcc, eRd);
    runJob(40, 30, eAcc, eRd, 1'b1, "restart_ignored");

    begin
      int d0;
      @(negedge clk);
      iX = 13'd0; iY = 13'd0; iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      repeat (49) @(negedge clk);
      d0 = doneCount;
      iRST = 1'b1;
      @(negedge clk);
      iRST = 1'b0;
      check("abort_busy", oBusy, 0);
      check("abort_corr", oCorr, 0);
      check("abort_rd", oFrameRd, 0);
      repeat (300) @(negedge clk);
      check("abort_nodone", doneCount - d0, 0);
    end
    model(20, 10, eAcc, eRd);
    runJob(20, 10, eAcc, eRd, 1'b0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
